serial_add_ctrl: RTL

Sequencer that time-shares one instance of the team's 4-bit ripple adder (Adder4b) to add or subtract wide operands, one nibble per clock, least-significant nibble first.
It latches operands on start, holds the inter-nibble carry in a register, and assembles the wide sum.
It then reports carry-out, signed overflow and a one-cycle done pulse.
It sits between a requester (switch/FSM front-end on the lab board) and the shared adder datapath.

---
 rtl/serial_add_ctrl_pkg.sv | 5 +
 rtl/serial_add_ctrl_adder4b.sv | 18 +
 rtl/serial_add_ctrl.sv | 74 +++++++
 3 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl_pkg: shared constants and state encoding for the serial adder sequencer
package serial_add_ctrl_pkg;
    localparam int NIBBLE_W = 4;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
endpackage

// File: rtl/serial_add_ctrl_adder4b.sv
// Adder4b: 4-bit ripple-carry adder, the shared nibble datapath
module Adder4b
    import serial_add_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);
    logic [NIBBLE_W:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[NIBBLE_W];
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: nibble-serial wide add/subtract sequencer around one shared Adder4b
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          op_sub,
    input  logic                          Cin,
    input  logic [NIBBLE_W*NIBBLES-1:0]   A,
    input  logic [NIBBLE_W*NIBBLES-1:0]   B,
    output logic                          busy,
    output logic                          done,
    output logic [NIBBLE_W*NIBBLES-1:0]   S,
    output logic                          Cout,
    output logic                          ovf
);
    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    state_t state, state_n;
    logic [W-1:0] a_reg, b_reg, work, work_n;
    logic [IW-1:0] idx;
    logic [NIBBLE_W-1:0] sn;
    logic carry, cn, last, accept;
    Adder4b u_add (
        .a(a_reg[idx*NIBBLE_W +: NIBBLE_W]),
        .b(b_reg[idx*NIBBLE_W +: NIBBLE_W]),
        .cin(carry),
        .s(sn),
        .cout(cn)
    );
    assign busy   = state == ST_RUN;
    assign done   = state == ST_DONE;
    assign last   = idx == IW'(NIBBLES - 1);
    assign accept = start && !busy;
    always_comb begin
        work_n = work;
        work_n[idx*NIBBLE_W +: NIBBLE_W] = sn;
        state_n = (accept || (busy && !last)) ? ST_RUN : busy ? ST_DONE : ST_IDLE;
    end
    // the final nibble lands in work_n so results publish on the edge entering DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            a_reg <= '0;
            b_reg <= '0;
            work  <= '0;
            idx   <= '0;
            carry <= 1'b0;
            S     <= '0;
            Cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                a_reg <= A;
                b_reg <= op_sub ? ~B : B;
                carry <= op_sub | Cin;
                idx   <= '0;
            end else if (busy) begin
                work  <= work_n;
                carry <= cn;
                idx   <= idx + IW'(1);
                if (last) begin
                    S    <= work_n;
                    Cout <= cn;
                    ovf  <= (a_reg[W-1] == b_reg[W-1]) && (work_n[W-1] != a_reg[W-1]);
                end
            end
        end
    end
endmodule
